// File: rtl/mul_add_acc_pkg.sv
// Shared types and helpers for the mul_add_acc dot-product accumulator.
package mul_add_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int cntWidth(input int maxLen);
        return $clog2(maxLen + 1);
    endfunction

endpackage

// File: rtl/mul_add_acc_muladduns.sv
// Combinational unsigned multiply-add P = X*Y + A, truncated to widthA bits.
module MulAddUns #(
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int widthA = 20,
    parameter int speed  = 0
) (
    input  logic [widthX-1:0] X,
    input  logic [widthY-1:0] Y,
    input  logic [widthA-1:0] A,
    output logic [widthA-1:0] P
);

    generate
        if (speed == 0) begin : g_shift_add
            // Slow form: ripple of shifted partial products, one per X bit.
            logic [widthA-1:0] prod;
            always_comb begin
                prod = '0;
                for (int i = 0; i < widthX; i++) begin
                    if (X[i]) prod = prod + (widthA'(Y) << i);
                end
            end
            assign P = prod + A;
        end else begin : g_direct
            assign P = widthA'(X) * widthA'(Y) + A;
        end
    endgenerate

endmodule

// File: rtl/mul_add_acc.sv
// Sequential dot-product accumulator: streams (x, y) pairs through MulAddUns,
// feeding the registered sum back as the augend, and hands out the total.
module mul_add_acc
    import mul_add_acc_pkg::*;
#(
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int widthA = 20,
    parameter int speed  = 0,
    parameter int maxLen = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [widthX-1:0]             x_i,
    input  logic [widthY-1:0]             y_i,
    input  logic [widthA-1:0]             bias_i,
    input  logic                          last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [widthA-1:0]             acc_o,
    output logic [cntWidth(maxLen)-1:0]   cnt_o,
    output logic                          ovf_o,
    output logic                          err_o
);

    localparam int CW = cntWidth(maxLen);

    state_t            state;
    logic [widthA-1:0] acc;
    logic [widthA-1:0] a_sel;
    logic [widthA-1:0] p;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              ovf;
    logic              err;
    logic              wrap;
    logic              accept;

    // The first beat of a vector starts from the bias instead of the running sum.
    assign a_sel = (state == IDLE) ? bias_i : acc;

    MulAddUns #(
        .widthX(widthX),
        .widthY(widthY),
        .widthA(widthA),
        .speed (speed)
    ) u_mac (
        .X(x_i),
        .Y(y_i),
        .A(a_sel),
        .P(p)
    );

    // X*Y never reaches 2^widthA, so a truncated sum below its augend means it wrapped.
    assign wrap        = (p < a_sel);
    assign in_ready_o  = (state != OUT);
    assign out_valid_o = (state == OUT);
    assign accept      = in_valid_i && in_ready_o;
    assign cnt_inc     = cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= p;
                        cnt   <= CW'(1);
                        ovf   <= wrap;
                        err   <= 1'b0;
                        state <= (last_i || maxLen == 1) ? OUT : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= p;
                        cnt <= cnt_inc;
                        ovf <= ovf | wrap;
                        if (last_i) begin
                            state <= OUT;
                        end else if (cnt_inc == CW'(maxLen)) begin
                            state <= OUT;
                            err   <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign acc_o = acc;
    assign cnt_o = cnt;
    assign ovf_o = ovf;
    assign err_o = err;

endmodule
